reduce_gate_pipe: RTL and testbench

- Parametrised, pipelined N-input reduction gate; next generation of the fixed 4-input AND primitive.
- Fixed-width single-function gate becomes a run-time selectable AND/OR/XOR/all-equal reduction over N_IN bits, built from LEAF-input register stages.
- Valid tagging and an optional saturating hit counter.
- Used in lab datapaths wherever a wide vector must be reduced at clock rate.

---
 rtl/reduce_gate_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_reduce_gate_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reduce_gate_pipe.sv
// Pipelined N_IN-bit AND/OR/XOR/EQ reduction with optional inversion and valid tagging.
// Optional saturating hit counter enabled by defining REDUCE_GATE_HIT_CNT_EN.
module reduce_gate_pipe #(
    parameter int N_IN  = 16,
    parameter int LEAF  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_data,
    input  logic [1:0]       op,
    input  logic             inv,
    output logic             out_valid,
    output logic             out_bit,
    output logic [CNT_W-1:0] hit_cnt,
    input  logic             hit_clr
);

    // Width of the partial vectors after s tree levels.
    function automatic int lvl_w(input int s);
        int w;
        w = N_IN;
        for (int i = 0; i < s; i++) begin
            w = (w + LEAF - 1) / LEAF;
        end
        return w;
    endfunction

    function automatic int calc_stages();
        int w;
        int n;
        w = N_IN;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (w > 1) begin
                w = (w + LEAF - 1) / LEAF;
                n = n + 1;
            end
        end
        return (n < 1) ? 1 : n;
    endfunction

    localparam int STAGES = calc_stages();

    logic            in_vld_q;
    logic [N_IN-1:0] in_data_q;
    logic [1:0]      in_op_q;
    logic            in_inv_q;

    // Input capture; data only loads on valid so ignored (possibly X) inputs never enter the tree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_vld_q  <= 1'b0;
            in_data_q <= {N_IN{1'b0}};
            in_op_q   <= 2'b00;
            in_inv_q  <= 1'b0;
        end else begin
            in_vld_q <= in_valid;
            if (in_valid) begin
                in_data_q <= in_data;
                in_op_q   <= op;
                in_inv_q  <= inv;
            end
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : gen_stage
        localparam int W_IN  = lvl_w(s);
        localparam int W_OUT = lvl_w(s + 1);

        logic [W_IN-1:0]  pa_s, po_s, px_s;
        logic             pv_s;
        logic [1:0]       pop_s;
        logic             pinv_s;
        logic [W_OUT-1:0] and_d, or_d, xor_d;
        logic [W_OUT-1:0] and_q, or_q, xor_q;
        logic             vld_q;
        logic [1:0]       op_q;
        logic             inv_q;

        if (s == 0) begin : gen_src_in
            assign pa_s   = in_data_q;
            assign po_s   = in_data_q;
            assign px_s   = in_data_q;
            assign pv_s   = in_vld_q;
            assign pop_s  = in_op_q;
            assign pinv_s = in_inv_q;
        end else begin : gen_src_prev
            assign pa_s   = gen_stage[s-1].and_q;
            assign po_s   = gen_stage[s-1].or_q;
            assign px_s   = gen_stage[s-1].xor_q;
            assign pv_s   = gen_stage[s-1].vld_q;
            assign pop_s  = gen_stage[s-1].op_q;
            assign pinv_s = gen_stage[s-1].inv_q;
        end

        for (genvar g = 0; g < W_OUT; g++) begin : gen_node
            logic [LEAF-1:0] la_s, lo_s, lx_s;
            for (genvar j = 0; j < LEAF; j++) begin : gen_leaf
                if (g * LEAF + j < W_IN) begin : gen_real
                    assign la_s[j] = pa_s[g*LEAF+j];
                    assign lo_s[j] = po_s[g*LEAF+j];
                    assign lx_s[j] = px_s[g*LEAF+j];
                end else begin : gen_pad
                    // Identity padding for ragged groups.
                    assign la_s[j] = 1'b1;
                    assign lo_s[j] = 1'b0;
                    assign lx_s[j] = 1'b0;
                end
            end
            assign and_d[g] = &la_s;
            assign or_d[g]  = |lo_s;
            assign xor_d[g] = ^lx_s;
        end

        // Tree level register; valid always shifts, partials and tags hold across bubbles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                and_q <= {W_OUT{1'b0}};
                or_q  <= {W_OUT{1'b0}};
                xor_q <= {W_OUT{1'b0}};
                op_q  <= 2'b00;
                inv_q <= 1'b0;
            end else begin
                vld_q <= pv_s;
                if (pv_s) begin
                    and_q <= and_d;
                    or_q  <= or_d;
                    xor_q <= xor_d;
                    op_q  <= pop_s;
                    inv_q <= pinv_s;
                end
            end
        end
    end

    logic last_and_s, last_or_s, last_xor_s, last_vld_s, last_inv_s;
    logic [1:0] last_op_s;
    logic r_s;
    logic out_valid_q, out_bit_q;

    assign last_and_s = gen_stage[STAGES-1].and_q[0];
    assign last_or_s  = gen_stage[STAGES-1].or_q[0];
    assign last_xor_s = gen_stage[STAGES-1].xor_q[0];
    assign last_vld_s = gen_stage[STAGES-1].vld_q;
    assign last_op_s  = gen_stage[STAGES-1].op_q;
    assign last_inv_s = gen_stage[STAGES-1].inv_q;

    // Final function select from the fully reduced partials.
    always_comb begin
        r_s = 1'b0;
        case (last_op_s)
            2'b00:   r_s = last_and_s;
            2'b01:   r_s = last_or_s;
            2'b10:   r_s = last_xor_s;
            2'b11:   r_s = last_and_s | ~last_or_s;
            default: r_s = 1'b0;
        endcase
    end

    // Output register; out_bit holds its last value during bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
        end else begin
            out_valid_q <= last_vld_s;
            if (last_vld_s) begin
                out_bit_q <= r_s ^ last_inv_s;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;

`ifdef REDUCE_GATE_HIT_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q;

    // Saturating count of results equal to 1; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q <= {CNT_W{1'b0}};
        end else if (hit_clr) begin
            hit_cnt_q <= {CNT_W{1'b0}};
        end else if (out_valid_q && out_bit_q && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_q <= hit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            hit_cnt_q <= hit_cnt_q;
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    logic hit_clr_unused;
    assign hit_clr_unused = hit_clr;
    assign hit_cnt        = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Scoreboard bench for reduce_gate_pipe: a 16-bit/LEAF 4 instance and a ragged 5-bit instance with a 2-bit counter.
module tb_reduce_gate_pipe;

`ifdef REDUCE_GATE_HIT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        int   due;
        logic b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic        v16 = 1'b0, inv16 = 1'b0, clr16 = 1'b0, ov16, ob16;
    logic [15:0] d16 = 16'h0000;
    logic [1:0]  op16 = 2'b00;
    logic [7:0]  cnt16;
    logic        v5 = 1'b0, inv5 = 1'b0, clr5 = 1'b0, ov5, ob5;
    logic [4:0]  d5 = 5'b00000;
    logic [1:0]  op5 = 2'b00;
    logic [1:0]  cnt5;

    exp_t q16[$];
    exp_t q5[$];
    logic last16 = 1'b0, last5 = 1'b0;
    logic [7:0] e16 = 8'h00;
    logic [1:0] e5 = 2'b00;

    reduce_gate_pipe #(.N_IN(16), .LEAF(4), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_data(d16), .op(op16), .inv(inv16),
        .out_valid(ov16), .out_bit(ob16), .hit_cnt(cnt16), .hit_clr(clr16)
    );

    reduce_gate_pipe #(.N_IN(5), .LEAF(4), .CNT_W(2)) dut5 (
        .clk(clk), .rst(rst), .in_valid(v5), .in_data(d5), .op(op5), .inv(inv5),
        .out_valid(ov5), .out_bit(ob5), .hit_cnt(cnt5), .hit_clr(clr5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference: bitwise reductions over the low w bits; EQ as "every bit equals bit 0".
    function automatic logic ref_bit(input logic [15:0] d, input int w, input logic [1:0] o, input logic iv);
        logic a, orr, x, eq, b0, r;
        logic [15:0] t;
        a = 1'b1; orr = 1'b0; x = 1'b0; eq = 1'b1;
        t = d;
        b0 = d[0];
        for (int i = 0; i < w; i++) begin
            a   = a & t[0];
            orr = orr | t[0];
            x   = x ^ t[0];
            if (t[0] != b0) eq = 1'b0;
            t = t >> 1;
        end
        case (o)
            2'b00:   r = a;
            2'b01:   r = orr;
            2'b10:   r = x;
            default: r = eq;
        endcase
        return r ^ iv;
    endfunction

    task automatic drive(input logic a_v, input logic [15:0] a_d, input logic [1:0] a_op, input logic a_inv,
                         input logic b_v, input logic [4:0] b_d, input logic [1:0] b_op, input logic b_inv,
                         input logic clr);
        exp_t e;
        @(posedge clk);
        #1;
        v16 = a_v; op16 = a_op; inv16 = a_inv;
        d16 = a_v ? a_d : 16'bx;
        v5 = b_v; op5 = b_op; inv5 = b_inv;
        d5 = b_v ? b_d : 5'bx;
        clr16 = clr; clr5 = clr;
        if (a_v && !rst) begin
            e.due = cyc + 4; e.b = ref_bit(a_d, 16, a_op, a_inv);
            q16.push_back(e);
        end
        if (b_v && !rst) begin
            e.due = cyc + 4; e.b = ref_bit({11'b0, b_d}, 5, b_op, b_inv);
            q5.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 5'h0, 2'b00, 1'b0, 1'b0);
    endtask

    // Scoreboard compare on the falling edge, away from the active edge.
    always @(negedge clk) begin : sb
        exp_t e;
        logic hit;
        if (rst) begin
            check_val("rst_ov16", ov16, 1'b0);
            check_val("rst_ob16", ob16, 1'b0);
            check_val("rst_cnt16", cnt16, 8'h00);
            check_val("rst_ov5", ov5, 1'b0);
            check_val("rst_cnt5", cnt5, 2'b00);
            q16.delete(); q5.delete();
            last16 = 1'b0; last5 = 1'b0; e16 = 8'h00; e5 = 2'b00;
        end else begin
            check_val("cnt16", cnt16, e16);
            hit = 1'b0;
            if (q16.size() > 0 && q16[0].due == cyc) begin
                e = q16.pop_front();
                check_val("ov16", ov16, 1'b1);
                check_val("ob16", ob16, e.b);
                last16 = e.b; hit = e.b;
            end else begin
                check_val("ov16_idle", ov16, 1'b0);
                check_val("ob16_hold", ob16, last16);
            end
            if (CNT_ON) e16 = clr16 ? 8'h00 : ((hit && e16 != 8'hFF) ? e16 + 8'h01 : e16);

            check_val("cnt5", cnt5, e5);
            hit = 1'b0;
            if (q5.size() > 0 && q5[0].due == cyc) begin
                e = q5.pop_front();
                check_val("ov5", ov5, 1'b1);
                check_val("ob5", ob5, e.b);
                last5 = e.b; hit = e.b;
            end else begin
                check_val("ov5_idle", ov5, 1'b0);
                check_val("ob5_hold", ob5, last5);
            end
            if (CNT_ON) e5 = clr5 ? 2'b00 : ((hit && e5 != 2'b11) ? e5 + 2'b01 : e5);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-stream: two samples, then reset while a third is presented.
        drive(1'b1, 16'hFFFF, 2'b00, 1'b0, 1'b1, 5'h1F, 2'b00, 1'b0, 1'b0);
        drive(1'b1, 16'hFFFF, 2'b00, 1'b0, 1'b1, 5'h1F, 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        v16 = 1'b1; d16 = 16'hFFFF; op16 = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;
        v16 = 1'b0; v5 = 1'b0;
        idle(6);

        // AND / NAND plus ragged 5-bit AND, XOR, OR.
        drive(1'b1, 16'hFFFF, 2'b00, 1'b0, 1'b1, 5'b11111, 2'b00, 1'b0, 1'b0);
        drive(1'b1, 16'hFFFE, 2'b00, 1'b0, 1'b1, 5'b10000, 2'b10, 1'b0, 1'b0);
        drive(1'b1, 16'hFFFE, 2'b00, 1'b1, 1'b1, 5'b00000, 2'b01, 1'b0, 1'b0);
        idle(5);

        // Back-to-back mixed ops on the same data.
        for (int o = 0; o < 4; o++) drive(1'b1, 16'h0001, 2'(o), 1'b0, 1'b0, 5'h0, 2'b00, 1'b0, 1'b0);
        idle(5);

        // EQ with a bubble in between.
        drive(1'b1, 16'h0000, 2'b11, 1'b0, 1'b1, 5'b00000, 2'b11, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 5'h0, 2'b00, 1'b0, 1'b0);
        drive(1'b1, 16'hFFFF, 2'b11, 1'b0, 1'b1, 5'b01000, 2'b11, 1'b0, 1'b0);
        idle(5);

        // Counter: clear, then a run of hits into saturation, with a clear landing on a hit.
        drive(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 5'h0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++)
            drive(1'b0, 16'h0, 2'b00, 1'b0, (i < 8), 5'b11111, 2'b00, 1'b0, (i == 9));
        idle(3);

        // Random mix on both instances.
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0));
        idle(8);

        check_val("drain16", q16.size(), 32'd0);
        check_val("drain5", q5.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
